// File: rtl/fix_pkg.sv
// Shared constants, state encoding and helpers for the FIX byte front end.
package fix_pkg;

   localparam logic [7:0] SEP = 8'h3B;
   localparam logic [7:0] EQ  = 8'h3D;

   localparam int TAG_W          = 16;
   localparam int MAX_TAG_DIGITS = 5;
   localparam int CKSUM_TAG      = 10;
   // 5 decimal digits reach 99999, one bit wider than the tag port
   localparam int ACC_W          = 17;

   typedef enum logic [1:0] {
      ST_TAG,
      ST_VALUE,
      ST_SKIP
   } state_t;

   localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
   localparam logic [1:0] ERR_TAG_OVF  = 2'd2;
   localparam logic [1:0] ERR_EMPTY    = 2'd3;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

endpackage

// File: rtl/fix_cksum_acc.sv
// Running mod-256 message sum and decimal checksum-value accumulator.
module fix_cksum_acc
   import fix_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] din,
   input  logic       freeze,
   input  logic       digit,
   input  logic       clear,
   output logic       ok
);

   logic [7:0] sum;
   logic [7:0] base;
   logic       frozen;
   logic [9:0] dacc;
   logic [2:0] dcnt;
   logic       bad;

   // base is the sum through the last separator, so the checksum
   // tag digits are never part of the compared value
   always_ff @(posedge clk) begin
      if (reset) begin
         sum    <= '0;
         base   <= '0;
         frozen <= 1'b0;
         dacc   <= '0;
         dcnt   <= '0;
         bad    <= 1'b0;
      end else if (enable) begin
         if (clear) begin
            sum    <= '0;
            base   <= '0;
            frozen <= 1'b0;
            dacc   <= '0;
            dcnt   <= '0;
            bad    <= 1'b0;
         end else begin
            if (!frozen && !freeze) begin
               sum <= sum + din;
               if (din == SEP) base <= sum + din;
            end
            if (freeze) frozen <= 1'b1;
            if (digit) begin
               if (!is_digit(din)) begin
                  bad <= 1'b1;
               end else if (dcnt < 3'd3) begin
                  dacc <= dacc * 10'd10 + {6'd0, din[3:0]};
                  dcnt <= dcnt + 3'd1;
               end else begin
                  dcnt <= 3'd4;
               end
            end
         end
      end
   end

   assign ok = frozen && (dcnt == 3'd3) && !bad && (dacc == {2'b00, base});

endmodule

// File: rtl/fix_field_splitter.sv
// Splits a FIX byte stream into tag numbers, value bytes and field/message strobes.
module fix_field_splitter
   import fix_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       din,
   output logic             tag_valid,
   output logic [TAG_W-1:0] tag,
   output logic             val_valid,
   output logic [7:0]       val_byte,
   output logic             field_end,
   output logic             msg_end,
   output logic             cksum_ok,
   output logic             err,
   output logic [1:0]       err_code
);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [2:0]       tcnt;
   logic             vnz;
   logic             is_ck;
   logic             dig;
   logic             ck_freeze;
   logic             ck_digit;
   logic             ck_clear;
   logic             ck_ok;

   assign dig = is_digit(din);

   assign ck_freeze = enable && (state == ST_TAG) && (din == EQ)
                      && (tcnt != 3'd0) && (acc == ACC_W'(CKSUM_TAG));
   assign ck_digit  = enable && (state == ST_VALUE) && is_ck && (din != SEP);
   assign ck_clear  = enable && (state == ST_VALUE) && is_ck && (din == SEP);

   fix_cksum_acc u_cksum (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .din    (din),
      .freeze (ck_freeze),
      .digit  (ck_digit),
      .clear  (ck_clear),
      .ok     (ck_ok)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_TAG;
         acc       <= '0;
         tcnt      <= '0;
         vnz       <= 1'b0;
         is_ck     <= 1'b0;
         tag_valid <= 1'b0;
         tag       <= '0;
         val_valid <= 1'b0;
         val_byte  <= '0;
         field_end <= 1'b0;
         msg_end   <= 1'b0;
         cksum_ok  <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
      end else begin
         tag_valid <= 1'b0;
         val_valid <= 1'b0;
         field_end <= 1'b0;
         msg_end   <= 1'b0;
         cksum_ok  <= 1'b0;
         err       <= 1'b0;
         if (enable) begin
            unique case (state)
               ST_TAG: begin
                  if (dig) begin
                     if (tcnt == 3'(MAX_TAG_DIGITS)) begin
                        err      <= 1'b1;
                        err_code <= ERR_TAG_OVF;
                        state    <= ST_SKIP;
                     end else begin
                        acc  <= acc * ACC_W'(10) + ACC_W'(din[3:0]);
                        tcnt <= tcnt + 3'd1;
                     end
                  end else if (din == EQ && tcnt != 3'd0) begin
                     tag_valid <= 1'b1;
                     tag       <= acc[TAG_W-1:0];
                     is_ck     <= (acc == ACC_W'(CKSUM_TAG));
                     state     <= ST_VALUE;
                  end else if (din == EQ) begin
                     err      <= 1'b1;
                     err_code <= ERR_EMPTY;
                     state    <= ST_SKIP;
                  end else if (din == SEP) begin
                     err      <= 1'b1;
                     err_code <= ERR_EMPTY;
                     acc      <= '0;
                     tcnt     <= '0;
                  end else begin
                     err      <= 1'b1;
                     err_code <= ERR_BAD_CHAR;
                     state    <= ST_SKIP;
                  end
               end
               ST_VALUE: begin
                  if (din != SEP) begin
                     val_valid <= 1'b1;
                     val_byte  <= din;
                     vnz       <= 1'b1;
                  end else begin
                     if (vnz) begin
                        field_end <= 1'b1;
                        msg_end   <= is_ck;
                        cksum_ok  <= is_ck && ck_ok;
                     end else begin
                        err      <= 1'b1;
                        err_code <= ERR_EMPTY;
                     end
                     acc   <= '0;
                     tcnt  <= '0;
                     vnz   <= 1'b0;
                     is_ck <= 1'b0;
                     state <= ST_TAG;
                  end
               end
               ST_SKIP: begin
                  if (din == SEP) begin
                     acc   <= '0;
                     tcnt  <= '0;
                     state <= ST_TAG;
                  end
               end
               default: state <= ST_TAG;
            endcase
         end
      end
   end

endmodule

// File: doc/fix_field_splitter.md
Name: fix_field_splitter

Overview:
Byte-level front end of the FIX parser. It takes the raw inbound byte stream (one byte per `enable` strobe, field separator `;` = 0x3B) and splits it into tag/value fields. For each field it emits:
- a binary tag number,
- a stream of value bytes,
- a field-end strobe.

It also verifies the FIX CheckSum (tag 10) and flags message boundaries, so the session/application logic downstream works on fields instead of ASCII.

Parameters:
SEP, 8'h3B, field separator byte (SOH substitute)
EQ, 8'h3D, tag/value delimiter '='
TAG_W, 16, width of binary tag output
MAX_TAG_DIGITS, 5, maximum decimal digits accepted in a tag
CKSUM_TAG, 10, tag number carrying the checksum

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
enable  in  1  din valid this cycle; no backpressure
din  in  8  inbound byte
tag_valid  out  1  one-cycle pulse; tag holds a completed tag
tag  out  TAG_W  binary tag number, held until the next tag_valid
val_valid  out  1  one-cycle pulse per value byte
val_byte  out  8  value byte
field_end  out  1  one-cycle pulse, separator closing a valid field
msg_end  out  1  one-cycle pulse, checksum field closed
cksum_ok  out  1  valid with msg_end; 1 = checksum matched
err  out  1  one-cycle pulse on a framing error
err_code  out  2  1 = bad tag char, 2 = tag overflow, 3 = empty tag/value; held until next err

Behaviour:
- Reset state: all outputs 0, FSM in TAG, tag accumulator, digit count, running sum and checksum accumulator all cleared. Reset wins over enable in the same cycle. Reset mid-field discards the partial field and emits no outputs for it.
- Latency: every output is registered and appears exactly one cycle after the enable cycle of the byte that caused it.
- Cycles with enable=0 change no state and produce no pulses.
- TAG state:
  - Digit '0'..'9': acc = acc*10 + (din-0x30), count++.
  - A digit arriving with count already at MAX_TAG_DIGITS: err code 2, go to SKIP.
  - EQ with count>0: tag_valid pulse, tag=acc, go to VALUE.
  - EQ with count=0, or SEP: err code 3. After SEP stay in TAG; after EQ go to SKIP.
  - Any other byte: err code 1, go to SKIP.
- VALUE state:
  - Byte != SEP: val_valid pulse with val_byte=din, value count++.
  - SEP with value count>0: field_end pulse, clear tag accumulator and counts, go to TAG.
  - SEP with value count=0: err code 3, go to TAG.
- SKIP state: discard bytes; on SEP return to TAG. No val_valid or field_end is emitted for a skipped field.
- Checksum:
  - The running sum (8-bit, mod 256) adds every enabled byte from message start up to and including the SEP that precedes the CKSUM_TAG tag digits.
  - The sum is frozen once the current tag equals CKSUM_TAG, i.e. from the cycle after EQ.
  - While the tag is CKSUM_TAG, value digits accumulate in decimal.
  - On the closing SEP: msg_end=1 in the same cycle as field_end, and cksum_ok = (exactly 3 digits, all numeric, value == sum). Then clear the sum; the next byte starts a new message.
  - A non-digit in the checksum value forces cksum_ok=0. It is not an err.
- Errors do not reset the running sum. Only msg_end or reset clears it.

Decomposition:
- Shared package fix_pkg holds:
  - SEP and EQ constants,
  - the state enum (TAG, VALUE, SKIP),
  - the err_code constants (ERR_BAD_CHAR=1, ERR_TAG_OVF=2, ERR_EMPTY=3),
  - CKSUM_TAG.
- Sub-module fix_cksum_acc: running mod-256 sum, freeze and clear controls, 3-digit decimal accumulator, compare output.
- The FSM and tag decode stay in fix_field_splitter.

Test Plan:
- Bytes 38 3D 41 3B ("8=A;") -> tag_valid with tag=8 one cycle after 3D; val_valid val_byte=41; field_end after 3B; err never set.
- "8=A;" then "10=241;" (sum 0x38+0x3D+0x41+0x3B = 0xF1 = 241) -> msg_end=1, cksum_ok=1. Repeating with "10=240;" -> msg_end=1, cksum_ok=0.
- "123456=X;" -> err=1, err_code=2 one cycle after the 6th digit '6'. No tag_valid or val_valid. The next field "9=B;" parses with tag=9.
- "a=1;" -> err code 1 on 'a'; skip to the separator. "35=;" -> tag_valid tag=35, then err code 3 on 3B, no field_end.
- Bytes with enable toggling every other cycle -> same output sequence as contiguous input, with no pulses in idle cycles.
- reset asserted after "35=AB" -> all outputs 0 next cycle. Then "8=A;10=241;" -> cksum_ok=1, proving the sum was cleared.
